// File: rtl/mf_pkg.sv
// Shared matched-filter constants and FSM state encoding, common to the
// capture buffer and the MIF streamer.
package mf_pkg;

   localparam int MF_DATA_WIDTH = 16;
   localparam int MF_LENGTH     = 10000;
   localparam int MF_ADDR_WIDTH = 20;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_READOUT = 2'd2,
      ST_DONE    = 2'd3
   } mf_state_e;

   function automatic int mf_ram_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/mf_capture_ram.sv
// Simple dual-port capture RAM: one write port and one registered read port
// whose output register can be synchronously cleared.
module mf_capture_ram #(
   parameter int DEPTH = 10000,
   parameter int WIDTH = 32,
   parameter int AW    = 14
) (
   input  logic             clock,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic             rd_clr_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port; contents survive reset
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Read register holds its value between requests
   always_ff @(posedge clock) begin
      if (rd_clr_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mf_capture_buffer.sv
// Capture buffer at the tail of the matched-filter chain: stores LENGTH
// complex samples, flags completion, then replays them on request.
module mf_capture_buffer
   import mf_pkg::*;
#(
   parameter int LENGTH     = MF_LENGTH,
   parameter int DATA_WIDTH = MF_DATA_WIDTH,
   parameter int ADDR_WIDTH = MF_ADDR_WIDTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         inputValid,
   input  logic signed [DATA_WIDTH-1:0] inputRe,
   input  logic signed [DATA_WIDTH-1:0] inputIm,
   input  logic                         readRequest,
   output logic                         captureDoneFlag,
   output logic                         overflowFlag,
   output logic                         dataOutValid,
   output logic signed [DATA_WIDTH-1:0] dataOutRe,
   output logic signed [DATA_WIDTH-1:0] dataOutIm,
   output logic                         readDoneFlag
);

   localparam int RAM_AW = mf_ram_aw(LENGTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LENGTH - 1);
   localparam logic [ADDR_WIDTH-1:0] LEN_CNT  = ADDR_WIDTH'(LENGTH);

   mf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic                  cap_done_q, cap_done_d;
   logic                  ovf_q, ovf_d;
   logic                  rd_done_q, rd_done_d;
   logic                  out_valid_q, out_valid_d;
   logic                  wr_en_s, rd_en_s, rd_clr_s;
   logic [2*DATA_WIDTH-1:0] rd_data_s;

   mf_capture_ram #(
      .DEPTH (LENGTH),
      .WIDTH (2*DATA_WIDTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clock     (clock),
      .wr_en_i   (wr_en_s),
      .wr_addr_i (wr_cnt_q[RAM_AW-1:0]),
      .wr_data_i ({inputRe, inputIm}),
      .rd_en_i   (rd_en_s),
      .rd_clr_i  (reset | rd_clr_s),
      .rd_addr_i (rd_cnt_q[RAM_AW-1:0]),
      .rd_data_o (rd_data_s)
   );

   // Next-state, counter and flag logic
   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      cap_done_d  = cap_done_q;
      ovf_d       = ovf_q;
      rd_done_d   = rd_done_q;
      out_valid_d = 1'b0;
      wr_en_s     = 1'b0;
      rd_en_s     = 1'b0;
      rd_clr_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_CAPTURE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            if (inputValid) begin
               wr_en_s  = 1'b1;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LAST_IDX) begin
                  cap_done_d = 1'b1;
                  state_d    = ST_READOUT;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_READOUT: begin
            if (inputValid) begin
               ovf_d = 1'b1;
            end else begin
               ovf_d = ovf_q;
            end
            // The last sample is on the outputs when the counter has wrapped to LENGTH
            if (out_valid_q && (rd_cnt_q == LEN_CNT)) begin
               state_d   = ST_DONE;
               rd_done_d = 1'b1;
               rd_clr_s  = 1'b1;
            end else if (readRequest && (rd_cnt_q != LEN_CNT)) begin
               rd_en_s     = 1'b1;
               rd_cnt_d    = rd_cnt_q + 1'b1;
               out_valid_d = 1'b1;
            end else begin
               state_d = ST_READOUT;
            end
         end
         ST_DONE: begin
            if (enable) begin
               state_d    = ST_CAPTURE;
               wr_cnt_d   = '0;
               rd_cnt_d   = '0;
               cap_done_d = 1'b0;
               ovf_d      = 1'b0;
               rd_done_d  = 1'b0;
            end else if (inputValid) begin
               ovf_d = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            cap_done_d = 1'b0;
            ovf_d      = 1'b0;
            rd_done_d  = 1'b0;
            rd_clr_s   = 1'b1;
         end
      endcase
   end

   // State, counter and flag registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         cap_done_q  <= 1'b0;
         ovf_q       <= 1'b0;
         rd_done_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         cap_done_q  <= cap_done_d;
         ovf_q       <= ovf_d;
         rd_done_q   <= rd_done_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign captureDoneFlag = cap_done_q;
   assign overflowFlag    = ovf_q;
   assign readDoneFlag    = rd_done_q;
   assign dataOutValid    = out_valid_q;
   assign dataOutRe       = rd_data_s[2*DATA_WIDTH-1:DATA_WIDTH];
   assign dataOutIm       = rd_data_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mf_capture_buffer.sv
// Scoreboard bench for mf_capture_buffer with LENGTH=8: the driver records
// what should have been captured and pushes expected replay beats; a monitor checks them.
module tb_mf_capture_buffer;

   localparam int L  = 8;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          inputValid = 1'b0;
   logic [DW-1:0] inputRe = '0;
   logic [DW-1:0] inputIm = '0;
   logic          readRequest = 1'b0;
   logic          captureDoneFlag, overflowFlag, dataOutValid, readDoneFlag;
   logic [DW-1:0] dataOutRe, dataOutIm;

   mf_capture_buffer #(.LENGTH(L), .DATA_WIDTH(DW), .ADDR_WIDTH(20)) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .inputValid      (inputValid),
      .inputRe         (inputRe),
      .inputIm         (inputIm),
      .readRequest     (readRequest),
      .captureDoneFlag (captureDoneFlag),
      .overflowFlag    (overflowFlag),
      .dataOutValid    (dataOutValid),
      .dataOutRe       (dataOutRe),
      .dataOutIm       (dataOutIm),
      .readDoneFlag    (readDoneFlag)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int            due;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } exp_t;

   exp_t          exp_q[$];
   logic [2*DW-1:0] stored[$];
   bit            capturing = 1'b0;
   int            rd_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every expected beat must appear exactly on its due cycle, nothing else.
   always @(negedge clock) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         check("missing_beat", 32'd0, 32'd1);
         void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         check("beat_valid", {31'd0, dataOutValid}, 32'd1);
         check("beat_re", {16'd0, dataOutRe}, {16'd0, exp_q[0].re});
         check("beat_im", {16'd0, dataOutIm}, {16'd0, exp_q[0].im});
         void'(exp_q.pop_front());
      end else if (dataOutValid) begin
         check("spurious_valid", 32'd1, 32'd0);
      end
   end

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; inputValid = 1'b0; readRequest = 1'b0;
      tick();
      reset = 1'b0;
      capturing = 1'b0;
      check("rst_capdone", {31'd0, captureDoneFlag}, 32'd0);
      check("rst_ovf", {31'd0, overflowFlag}, 32'd0);
      check("rst_rddone", {31'd0, readDoneFlag}, 32'd0);
      check("rst_valid", {31'd0, dataOutValid}, 32'd0);
      check("rst_data", {dataOutRe, dataOutIm}, 32'd0);
   endtask

   // Arm from IDLE/DONE; a simultaneous inputValid must not be stored.
   task automatic arm(input bit with_valid, input logic [DW-1:0] re, input logic [DW-1:0] im);
      enable = 1'b1; inputValid = with_valid; inputRe = re; inputIm = im;
      tick();
      enable = 1'b0; inputValid = 1'b0;
      capturing = 1'b1;
      stored.delete();
      rd_idx = 0;
   endtask

   task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
      inputValid = 1'b1; inputRe = re; inputIm = im;
      if (capturing && stored.size() < L) stored.push_back({re, im});
      if (stored.size() == L) capturing = 1'b0;
      tick();
      inputValid = 1'b0;
   endtask

   task automatic read_req(input bit r);
      readRequest = r;
      if (r && rd_idx < L) begin
         exp_q.push_back('{due: cyc + 1, re: stored[rd_idx][2*DW-1:DW], im: stored[rd_idx][DW-1:0]});
         rd_idx++;
      end
      tick();
      readRequest = 1'b0;
   endtask

   // Gapped readout; after the last request, readDoneFlag rises one cycle past the last beat.
   task automatic readout_random();
      while (rd_idx < L) begin
         if ($urandom_range(0, 2) != 0) read_req(1'b1);
         else read_req(1'b0);
      end
      check("rddone_pre", {31'd0, readDoneFlag}, 32'd0);
      tick();
      check("rddone", {31'd0, readDoneFlag}, 32'd1);
      check("done_data_zero", {dataOutRe, dataOutIm}, 32'd0);
      check("done_capdone", {31'd0, captureDoneFlag}, 32'd1);
   endtask

   initial begin
      logic [DW-1:0] v;
      do_reset();

      // Scenario 1: contiguous capture re=k, im=-k
      arm(1'b0, '0, '0);
      for (int k = 0; k < L; k++) begin
         if (k == L - 1) check("capdone_early", {31'd0, captureDoneFlag}, 32'd0);
         send(DW'(k), DW'(-k));
      end
      check("s1_capdone", {31'd0, captureDoneFlag}, 32'd1);
      check("s1_ovf", {31'd0, overflowFlag}, 32'd0);

      // Scenario 2: readRequest held 10 cycles
      for (int k = 0; k < 10; k++) read_req(1'b1);
      check("s2_rddone", {31'd0, readDoneFlag}, 32'd1);
      check("s2_valid_low", {31'd0, dataOutValid}, 32'd0);

      // Scenario 3: alternating valid, gapped requests
      arm(1'b0, '0, '0);
      check("s3_flags_clear", {29'd0, captureDoneFlag, overflowFlag, readDoneFlag}, 32'd0);
      for (int k = 0; k < L; k++) begin
         send(DW'(k), DW'(-k));
         tick();
      end
      check("s3_capdone", {31'd0, captureDoneFlag}, 32'd1);
      readout_random();

      // Scenario 4: enable with a simultaneous valid, then overflow after full
      do_reset();
      arm(1'b1, 16'h7FFF, 16'h7FFF);
      for (int k = 0; k < L; k++) begin
         v = DW'($urandom);
         send(v, ~v);
         if ($urandom_range(0, 1) == 1) tick();
      end
      check("s4_ovf_pre", {31'd0, overflowFlag}, 32'd0);
      send(16'h1111, 16'h2222);
      send(16'h3333, 16'h4444);
      check("s4_ovf", {31'd0, overflowFlag}, 32'd1);
      readout_random();
      check("s4_ovf_sticky", {31'd0, overflowFlag}, 32'd1);

      // Scenario 5: reset after 5 writes, then fresh capture
      do_reset();
      arm(1'b0, '0, '0);
      for (int k = 0; k < 5; k++) send(DW'(50 + k), DW'(k));
      do_reset();
      arm(1'b0, '0, '0);
      for (int k = 0; k < L; k++) send(DW'(100 + k), DW'($urandom));
      readout_random();

      // Scenario 6: overflow in DONE, re-arm clears all, extremes preserved
      send(16'h0001, 16'h0002);
      check("s6_ovf_done", {31'd0, overflowFlag}, 32'd1);
      arm(1'b0, '0, '0);
      check("s6_flags_clear", {29'd0, captureDoneFlag, overflowFlag, readDoneFlag}, 32'd0);
      for (int k = 0; k < L; k++) begin
         if (k % 2 == 0) send(16'h8000, 16'h7FFF);
         else send(DW'($urandom), DW'($urandom));
      end
      readout_random();

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
